// File: rtl/uart_pkg.sv
// Shared UART constants: byte width, default RX FIFO depth and the status-register bit layout.
package uart_pkg;
  localparam int UART_DATA_W             = 8;
  localparam int UART_RX_FIFO_DEPTH_LOG2 = 4;

  // Bit positions of {overflow, full, empty} in the RX status register seen by the bus decoder
  localparam int UART_STAT_EMPTY_BIT = 0;
  localparam int UART_STAT_FULL_BIT  = 1;
  localparam int UART_STAT_OVF_BIT   = 2;

  typedef struct packed {
    logic overflow;
    logic full;
    logic empty;
  } uart_rx_stat_t;
endpackage

// File: rtl/uart_rx_fifo_if.sv
// Receiver-to-FIFO and CPU-read signals of the UART RX FIFO.
// master = receiver/CPU side, slave = the FIFO.
interface uart_rx_fifo_if
  import uart_pkg::*;
#(
  parameter int DATA_W     = UART_DATA_W,
  parameter int DEPTH_LOG2 = UART_RX_FIFO_DEPTH_LOG2
);
  logic                  rx_fin;
  logic [DATA_W-1:0]     rx_data;
  logic                  rd_en;
  logic                  clr_ovf;
  logic [DATA_W-1:0]     rd_data;
  logic                  empty;
  logic                  full;
  logic [DEPTH_LOG2:0]   count;
  logic                  overflow;
  logic                  irq;

  modport master (
    output rx_fin, rx_data, rd_en, clr_ovf,
    input  rd_data, empty, full, count, overflow, irq
  );

  modport slave (
    input  rx_fin, rx_data, rd_en, clr_ovf,
    output rd_data, empty, full, count, overflow, irq
  );
endinterface

// File: rtl/uart_fifo_mem.sv
// FIFO storage: register array with synchronous write and asynchronous read.
// Deliberately unreset; contents are don't-care until written.
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int DATA_W     = UART_DATA_W,
  parameter int DEPTH_LOG2 = UART_RX_FIFO_DEPTH_LOG2
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [DATA_W-1:0]     rdata
);
  logic [DATA_W-1:0] mem_q [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];
endmodule

// File: rtl/uart_rx_fifo.sv
// UART RX FIFO: pushes one byte per rx_fin rising edge, FWFT read port, sticky overflow.
// Define UART_RX_FIFO_IRQ_EN to get a registered threshold/overflow irq; otherwise irq is 0.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W     = UART_DATA_W,
  parameter int DEPTH_LOG2 = UART_RX_FIFO_DEPTH_LOG2,
  parameter int IRQ_THRESH = 1
) (
  input  logic           sysclk,
  input  logic           reset,
  uart_rx_fifo_if.slave  bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CNT_W = DEPTH_LOG2 + 1;

  if (IRQ_THRESH < 1 || IRQ_THRESH > DEPTH) begin : g_bad_thresh
    $error("uart_rx_fifo: IRQ_THRESH out of range 1..DEPTH");
  end

  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  fin_q, fin_d;
  logic                  ovf_q, ovf_d;
  logic                  push, pop, wr_en, drop, empty, full;
  logic [DATA_W-1:0]     mem_rdata;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));
  assign push  = bus.rx_fin & ~fin_q;
  assign pop   = bus.rd_en & ~empty;
  // When full, a push only lands if a pop frees the slot on the same edge
  assign wr_en = push & (~full | pop);
  assign drop  = push & full & ~pop;

  always_comb begin
    fin_d    = bus.rx_fin;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;
    count_d = count_q + CNT_W'(wr_en) - CNT_W'(pop);
    if (drop)             ovf_d = 1'b1;
    else if (bus.clr_ovf) ovf_d = 1'b0;
  end

  // fin_q resets high so a receiver already holding rx_fin at release does not push
  always_ff @(posedge sysclk) begin
    if (!reset) begin
      fin_q    <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      fin_q    <= fin_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  uart_fifo_mem #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_mem (
    .clk   (sysclk),
    .we    (wr_en),
    .waddr (wr_ptr_q),
    .wdata (bus.rx_data),
    .raddr (rd_ptr_q),
    .rdata (mem_rdata)
  );

`ifdef UART_RX_FIFO_IRQ_EN
  logic irq_q, irq_d;

  assign irq_d = (count_d >= CNT_W'(IRQ_THRESH)) | ovf_d;

  always_ff @(posedge sysclk) begin
    if (!reset) irq_q <= 1'b0;
    else        irq_q <= irq_d;
  end

  assign bus.irq = irq_q;
`else
  assign bus.irq = 1'b0;
`endif

  assign bus.rd_data  = empty ? '0 : mem_rdata;
  assign bus.empty    = empty;
  assign bus.full     = full;
  assign bus.count    = count_q;
  assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo (depth 16, IRQ_THRESH 4); irq expectations follow UART_RX_FIFO_IRQ_EN.
module tb_uart_rx_fifo;
  logic sysclk = 1'b0;
  logic reset  = 1'b0;
  int   total  = 0;
  int   bad    = 0;

  always #5 sysclk = ~sysclk;

  uart_rx_fifo_if #(.DATA_W(8), .DEPTH_LOG2(4)) ifc ();

  uart_rx_fifo #(.DATA_W(8), .DEPTH_LOG2(4), .IRQ_THRESH(4)) dut (
    .sysclk (sysclk),
    .reset  (reset),
    .bus    (ifc)
  );

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic irq_exp(int cnt, logic ovf);
`ifdef UART_RX_FIFO_IRQ_EN
    return (cnt >= 4) | ovf;
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk_state(string tag, int cnt, logic ovf);
    chk({tag, ".count"}, 32'(ifc.count), 32'(cnt));
    chk({tag, ".empty"}, 32'(ifc.empty), 32'(cnt == 0));
    chk({tag, ".full"},  32'(ifc.full),  32'(cnt == 16));
    chk({tag, ".ovf"},   32'(ifc.overflow), 32'(ovf));
    chk({tag, ".irq"},   32'(ifc.irq),   32'(irq_exp(cnt, ovf)));
  endtask

  task automatic push_byte(logic [7:0] b);
    ifc.rx_data = b;
    ifc.rx_fin  = 1'b1;
    tick();
    ifc.rx_fin  = 1'b0;
    tick();
  endtask

  initial begin
    ifc.rx_fin  = 1'b1;
    ifc.rx_data = 8'h00;
    ifc.rd_en   = 1'b0;
    ifc.clr_ovf = 1'b0;

    // 1: reset with rx_fin high, release, no push; then one edge pushes A5
    tick(); tick();
    chk_state("rst", 0, 1'b0);
    chk("rst.rd_data", 32'(ifc.rd_data), 32'h0);
    reset = 1'b1;
    tick(); tick();
    chk_state("rel_fin_high", 0, 1'b0);
    ifc.rx_fin = 1'b0;
    tick();
    ifc.rx_data = 8'hA5;
    ifc.rx_fin  = 1'b1;
    tick();
    chk("a5.rd_data", 32'(ifc.rd_data), 32'hA5);
    chk_state("a5", 1, 1'b0);
    tick(); tick();
    chk_state("a5_held", 1, 1'b0);
    ifc.rx_fin = 1'b0;
    ifc.rd_en  = 1'b1;
    chk("a5.pop_data", 32'(ifc.rd_data), 32'hA5);
    tick();
    ifc.rd_en = 1'b0;
    chk_state("a5_popped", 0, 1'b0);
    chk("a5.empty_data", 32'(ifc.rd_data), 32'h0);

    // 2: fill, overflow, clear, drain in order (irq falls at count 3)
    for (int i = 0; i < 16; i++) begin
      push_byte(8'(i));
      chk_state("fill", i + 1, 1'b0);
    end
    push_byte(8'hFF);
    chk_state("ovf", 16, 1'b1);
    ifc.clr_ovf = 1'b1;
    tick();
    ifc.clr_ovf = 1'b0;
    chk_state("ovf_clr", 16, 1'b0);
    ifc.rd_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("drain.rd_data", 32'(ifc.rd_data), 32'(i));
      tick();
      chk_state("drain", 15 - i, 1'b0);
    end
    ifc.rd_en = 1'b0;

    // 3: push and pop together while full
    for (int i = 0; i < 16; i++) push_byte(8'h10 + 8'(i));
    ifc.rx_data = 8'h3C;
    ifc.rx_fin  = 1'b1;
    ifc.rd_en   = 1'b1;
    chk("full_rw.head", 32'(ifc.rd_data), 32'h10);
    tick();
    ifc.rx_fin = 1'b0;
    ifc.rd_en  = 1'b0;
    chk_state("full_rw", 16, 1'b0);
    tick();
    ifc.rd_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("full_rw.rd_data", 32'(ifc.rd_data), (i < 15) ? 32'(8'h11 + 8'(i)) : 32'h3C);
      tick();
    end
    ifc.rd_en = 1'b0;
    chk_state("full_rw_drained", 0, 1'b0);

    // 4: push with rd_en while empty -> no pop
    ifc.rx_data = 8'h5A;
    ifc.rx_fin  = 1'b1;
    ifc.rd_en   = 1'b1;
    tick();
    ifc.rx_fin = 1'b0;
    ifc.rd_en  = 1'b0;
    chk("empty_rw.rd_data", 32'(ifc.rd_data), 32'h5A);
    chk_state("empty_rw", 1, 1'b0);
    ifc.rd_en = 1'b1;
    tick();
    ifc.rd_en = 1'b0;
    chk_state("empty_rw_pop", 0, 1'b0);

    // 5: set wins over clr_ovf, then clr_ovf alone clears
    for (int i = 0; i < 16; i++) push_byte(8'h20 + 8'(i));
    push_byte(8'hEE);
    chk_state("ovf2", 16, 1'b1);
    ifc.rx_data = 8'h77;
    ifc.rx_fin  = 1'b1;
    ifc.clr_ovf = 1'b1;
    tick();
    ifc.rx_fin = 1'b0;
    chk_state("set_wins", 16, 1'b1);
    tick();
    ifc.clr_ovf = 1'b0;
    chk_state("clr_alone", 16, 1'b0);
    chk("ovf2.head", 32'(ifc.rd_data), 32'h20);

    // Reset mid-operation discards contents; FIFO works afterwards
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk_state("mid_rst", 0, 1'b0);
    chk("mid_rst.rd_data", 32'(ifc.rd_data), 32'h0);
    tick();
    push_byte(8'h99);
    chk("post_rst.rd_data", 32'(ifc.rd_data), 32'h99);
    chk_state("post_rst", 1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
